mdsa_phase_sequencer: RTL and testbench

//  Parametrised phase sequencer for the multidimensional bitonic sorter array. One START steps the

---
 rtl/mdsa_phase_sequencer_pkg.sv | 23 ++
 rtl/mdsa_phase_sequencer_counter.sv | 28 ++
 rtl/mdsa_phase_sequencer.sv | 152 +++++++++++++++
 tb/tb_mdsa_phase_sequencer.sv | 350 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mdsa_phase_sequencer_pkg.sv
// rtl/mdsa_phase_sequencer_pkg.sv - shared types, direction patterns and clog2 for the phase sequencer
package mdsa_phase_sequencer_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PHASE = 2'd1,
      ST_DRAIN = 2'd2
   } state_e;

   // Alternating compare patterns, truncated to the direction width by the user (DIR_W <= 64).
   localparam logic [63:0] DIR_ALT_A = {32{2'b01}};
   localparam logic [63:0] DIR_ALT_B = {32{2'b10}};

   function automatic int clog2(input int v);
      int r;
      r = 1;
      for (int i = 1; i < 31; i++) begin
         if ((1 << i) < v) r = i + 1;
      end
      return r;
   endfunction

endpackage

// File: rtl/mdsa_phase_sequencer_counter.sv
// rtl/mdsa_phase_sequencer_counter.sv - terminal counter with clear, enable and last-tick flag
module mdsa_phase_counter #(
   parameter int W   = 4,
   parameter int MAX = 8
)(
   input  logic clk,
   input  logic rst_n,
   input  logic clr_i,
   input  logic en_i,
   output logic last_o
);

   logic [W-1:0] count_q;

   // Saturates at MAX so a frozen or overrun count never wraps.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         count_q <= '0;
      end else if (clr_i) begin
         count_q <= '0;
      end else if (en_i && (count_q != W'(MAX))) begin
         count_q <= count_q + 1'b1;
      end
   end

   assign last_o = (count_q == W'(MAX));

endmodule

// File: rtl/mdsa_phase_sequencer.sv
// rtl/mdsa_phase_sequencer.sv - sequences the bitonic sorter through its compare phases and a drain phase
module mdsa_phase_sequencer
   import mdsa_phase_sequencer_pkg::*;
#(
   parameter int                    NUM_PHASES  = 6,
   parameter int                    PHASE_DELAY = 8,
   parameter int                    DIR_W       = 8,
   parameter logic [NUM_PHASES-1:0] ALT_MASK    = 6'b001010,
   localparam int                   PH_W        = clog2(NUM_PHASES + 2),
   localparam int                   CNT_W       = clog2(PHASE_DELAY + 1)
)(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             start,
   input  logic             descend,
   input  logic             abort,
   output logic [DIR_W-1:0] direction,
   output logic             ready,
   output logic             busy,
   output logic             trans,
   output logic             output_enable,
   output logic [PH_W-1:0]  phase
);

   localparam logic [DIR_W-1:0] PAT_A = DIR_ALT_A[DIR_W-1:0];
   localparam logic [DIR_W-1:0] PAT_B = DIR_ALT_B[DIR_W-1:0];

   state_e            state_q, state_d;
   logic [PH_W-1:0]   phase_q, phase_d;
   logic [DIR_W-1:0]  dir_q, dir_d;
   logic              desc_q, desc_d;
   logic              trans_q, trans_d;
   logic              oe_q, oe_d;
   logic              ready_q, ready_d;
   logic              busy_q, busy_d;
   logic              cnt_clr;
   logic              cnt_last;

   // The pattern of an alternating phase depends on how many alternating phases precede it.
   function automatic logic [DIR_W-1:0] dir_for(input logic [PH_W-1:0] ph, input logic desc);
      logic [NUM_PHASES-1:0] mask;
      logic                  alt;
      logic                  par;
      logic [DIR_W-1:0]      pat;
      mask = ALT_MASK;
      alt  = 1'b0;
      par  = 1'b0;
      for (int i = 0; i < NUM_PHASES; i++) begin
         if (mask[i]) begin
            if (PH_W'(i + 1) == ph)     alt = 1'b1;
            else if (PH_W'(i + 1) < ph) par = ~par;
         end
      end
      pat = alt ? (par ? PAT_B : PAT_A) : '0;
      return desc ? ~pat : pat;
   endfunction

   assign cnt_clr = abort || (state_q == ST_IDLE) || (en && cnt_last);

   mdsa_phase_counter #(
      .W   (CNT_W),
      .MAX (PHASE_DELAY)
   ) u_counter (
      .clk    (clk),
      .rst_n  (rst_n),
      .clr_i  (cnt_clr),
      .en_i   (en),
      .last_o (cnt_last)
   );

   always_comb begin
      state_d = state_q;
      phase_d = phase_q;
      dir_d   = dir_q;
      desc_d  = desc_q;
      trans_d = 1'b0;
      oe_d    = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (start && en && !abort) begin
               state_d = ST_PHASE;
               phase_d = PH_W'(1);
               desc_d  = descend;
               dir_d   = dir_for(PH_W'(1), descend);
               trans_d = 1'b1;
            end
         end
         ST_PHASE: begin
            if (abort) begin
               state_d = ST_IDLE;
               phase_d = '0;
               dir_d   = '0;
            end else if (en && cnt_last) begin
               if (phase_q == PH_W'(NUM_PHASES)) state_d = ST_DRAIN;
               phase_d = phase_q + 1'b1;
               dir_d   = dir_for(phase_q + 1'b1, desc_q);
               trans_d = 1'b1;
            end
         end
         ST_DRAIN: begin
            if (abort) begin
               state_d = ST_IDLE;
               phase_d = '0;
               dir_d   = '0;
            end else if (en && cnt_last) begin
               state_d = ST_IDLE;
               phase_d = '0;
               dir_d   = '0;
               oe_d    = 1'b1;
            end
         end
         default: begin
            state_d = ST_IDLE;
            phase_d = '0;
            dir_d   = '0;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
      busy_d  = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         phase_q <= '0;
         dir_q   <= '0;
         desc_q  <= 1'b0;
         trans_q <= 1'b0;
         oe_q    <= 1'b0;
         ready_q <= 1'b1;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         phase_q <= phase_d;
         dir_q   <= dir_d;
         desc_q  <= desc_d;
         trans_q <= trans_d;
         oe_q    <= oe_d;
         ready_q <= ready_d;
         busy_q  <= busy_d;
      end
   end

   assign direction     = dir_q;
   assign ready         = ready_q;
   assign busy          = busy_q;
   assign trans         = trans_q;
   assign output_enable = oe_q;
   assign phase         = phase_q;

endmodule

// File: tb/tb_mdsa_phase_sequencer.sv
// tb/tb_mdsa_phase_sequencer.sv - self-checking bench for mdsa_phase_sequencer
module tb_mdsa_phase_sequencer;

   logic       clk, rst_n;
   logic       en, start, descend, abort;
   logic       en2, start2, descend2, abort2;
   logic [7:0] dir1;
   logic [3:0] dir2;
   logic [2:0] ph1, ph2;
   logic       rdy1, bsy1, tr1, oe1, rdy2, bsy2, tr2, oe2;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;

   // Reference model: elapsed enabled cycles since the accepted start.
   int   m_P[2]    = '{6, 3};
   int   m_D[2]    = '{8, 2};
   int   m_W[2]    = '{8, 4};
   int   m_mask[2] = '{6'b001010, 3'b010};
   bit   m_act[2];
   int   m_t[2];
   bit   m_desc[2];
   logic e_tr[2];
   logic e_oe[2];

   mdsa_phase_sequencer u_dut (
      .clk(clk), .rst_n(rst_n), .en(en), .start(start), .descend(descend), .abort(abort),
      .direction(dir1), .ready(rdy1), .busy(bsy1), .trans(tr1), .output_enable(oe1), .phase(ph1)
   );

   mdsa_phase_sequencer #(
      .NUM_PHASES(3), .PHASE_DELAY(2), .DIR_W(4), .ALT_MASK(3'b010)
   ) u_small (
      .clk(clk), .rst_n(rst_n), .en(en2), .start(start2), .descend(descend2), .abort(abort2),
      .direction(dir2), .ready(rdy2), .busy(bsy2), .trans(tr2), .output_enable(oe2), .phase(ph2)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int e_phase(int id);
      if (!m_act[id]) return 0;
      return m_t[id] / (m_D[id] + 1) + 1;
   endfunction

   function automatic logic [7:0] e_dir(int id);
      int p, n;
      logic [7:0] pat;
      pat = 8'h00;
      if (!m_act[id]) return pat;
      p = e_phase(id);
      if (p <= m_P[id] && ((m_mask[id] >> (p - 1)) & 1) == 1) begin
         n = 0;
         for (int k = 0; k < p - 1; k++) if (((m_mask[id] >> k) & 1) == 1) n++;
         for (int b = 0; b < m_W[id]; b++)
            if ((b % 2 == 0) != (n % 2 == 1)) pat = pat | (8'h01 << b);
      end
      if (m_desc[id]) pat = pat ^ 8'((1 << m_W[id]) - 1);
      return pat;
   endfunction

   task automatic model_step(input int id, input logic s, input logic e, input logic a, input logic d);
      e_tr[id] = 1'b0;
      e_oe[id] = 1'b0;
      if (!m_act[id]) begin
         if (s && e && !a) begin
            m_act[id] = 1'b1; m_t[id] = 0; m_desc[id] = d; e_tr[id] = 1'b1;
         end
      end else if (a) begin
         m_act[id] = 1'b0;
      end else if (e) begin
         m_t[id]++;
         if (m_t[id] == (m_P[id] + 1) * (m_D[id] + 1)) begin
            m_act[id] = 1'b0; e_oe[id] = 1'b1;
         end else if (m_t[id] % (m_D[id] + 1) == 0) begin
            e_tr[id] = 1'b1;
         end
      end
   endtask

   task automatic model_reset();
      for (int id = 0; id < 2; id++) begin
         m_act[id] = 1'b0; m_t[id] = 0; m_desc[id] = 1'b0; e_tr[id] = 1'b0; e_oe[id] = 1'b0;
      end
   endtask

   task automatic tick();
      @(posedge clk);
      model_step(0, start, en, abort, descend);
      model_step(1, start2, en2, abort2, descend2);
      cyc++;
      #1;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (ph1 !== 3'd0 || dir1 !== 8'h00 || rdy1 !== 1'b1 || bsy1 !== 1'b0 || tr1 !== 1'b0 || oe1 !== 1'b0) begin
         errors++;
         $display("FAIL reset dut: ph %0d dir %h rdy %b bsy %b tr %b oe %b, want 0 00 1 0 0 0", ph1, dir1, rdy1, bsy1, tr1, oe1);
      end
      checks++;
      if (ph2 !== 3'd0 || dir2 !== 4'h0 || rdy2 !== 1'b1 || bsy2 !== 1'b0) begin
         errors++;
         $display("FAIL reset small: ph %0d dir %h rdy %b bsy %b, want 0 0 1 0", ph2, dir2, rdy2, bsy2);
      end
      rst_n = 1'b1;
   endtask

   task automatic test_sort(input bit desc);
      int t0, n_oe, oe_at;
      logic [7:0] ed;
      logic [7:0] seen[$];
      logic [7:0] want[7];
      want = '{8'h00, 8'h55, 8'h00, 8'hAA, 8'h00, 8'h00, 8'h00};
      descend = desc; start = 1'b1;
      tick();
      start = 1'b0; t0 = cyc; n_oe = 0; oe_at = -1;
      for (int i = 0; i < 70; i++) begin
         if (i > 0) tick();
         ed = e_dir(0);
         checks++;
         if (ph1 !== 3'(e_phase(0)) || dir1 !== ed || tr1 !== e_tr[0] || oe1 !== e_oe[0] || rdy1 !== !m_act[0] || bsy1 !== m_act[0]) begin
            errors++;
            $display("FAIL sort desc=%0d cyc %0d: ph %0d/%0d dir %h/%h tr %b/%b oe %b/%b rdy %b", desc, cyc, ph1, e_phase(0), dir1, ed, tr1, e_tr[0], oe1, e_oe[0], rdy1);
         end
         if (tr1) seen.push_back(dir1);
         if (oe1) begin n_oe++; oe_at = cyc; end
      end
      checks++;
      if (oe_at - t0 !== 63 || n_oe !== 1) begin
         errors++;
         $display("FAIL sort_timing desc=%0d: oe after %0d cycles (count %0d), want 63 (1)", desc, oe_at - t0, n_oe);
      end
      checks++;
      if (seen.size() !== 7) begin
         errors++;
         $display("FAIL sort_trans desc=%0d: %0d pulses, want 7", desc, seen.size());
      end else begin
         for (int k = 0; k < 7; k++) begin
            checks++;
            if (seen[k] !== (want[k] ^ (desc ? 8'hFF : 8'h00))) begin
               errors++;
               $display("FAIL sort_dir desc=%0d phase %0d: %h, want %h", desc, k + 1, seen[k], want[k] ^ (desc ? 8'hFF : 8'h00));
            end
         end
      end
   endtask

   task automatic test_en_freeze();
      int t0, oe_at, n_tr;
      logic [7:0] ed;
      descend = 1'b0; start = 1'b1;
      tick();
      start = 1'b0; t0 = cyc; oe_at = -1; n_tr = 1;
      for (int i = 1; i < 80; i++) begin
         en = (cyc >= t0 + 21 && cyc < t0 + 26) ? 1'b0 : 1'b1;
         tick();
         ed = e_dir(0);
         checks++;
         if (ph1 !== 3'(e_phase(0)) || dir1 !== ed || tr1 !== e_tr[0] || oe1 !== e_oe[0] || bsy1 !== m_act[0]) begin
            errors++;
            $display("FAIL en_freeze cyc %0d: ph %0d/%0d dir %h/%h tr %b/%b oe %b/%b", cyc, ph1, e_phase(0), dir1, ed, tr1, e_tr[0], oe1, e_oe[0]);
         end
         if (tr1) n_tr++;
         if (oe1) oe_at = cyc;
      end
      en = 1'b1;
      checks++;
      if (oe_at - t0 !== 68 || n_tr !== 7) begin
         errors++;
         $display("FAIL en_freeze_timing: oe after %0d, trans %0d, want 68 and 7", oe_at - t0, n_tr);
      end
   endtask

   task automatic test_abort();
      int t0, n_oe;
      logic [7:0] ed;
      descend = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; t0 = cyc; n_oe = 0;
      while (cyc < t0 + 29) tick();
      abort = 1'b1;
      tick();
      abort = 1'b0;
      checks++;
      if (ph1 !== 3'd0 || dir1 !== 8'h00 || rdy1 !== 1'b1 || bsy1 !== 1'b0) begin
         errors++;
         $display("FAIL abort: ph %0d dir %h rdy %b bsy %b, want 0 00 1 0", ph1, dir1, rdy1, bsy1);
      end
      for (int i = 0; i < 70; i++) begin
         tick();
         ed = e_dir(0);
         if (oe1) n_oe++;
         checks++;
         if (ph1 !== 3'(e_phase(0)) || dir1 !== ed || tr1 !== e_tr[0] || oe1 !== e_oe[0]) begin
            errors++;
            $display("FAIL abort_after cyc %0d: ph %0d/%0d dir %h/%h oe %b/%b", cyc, ph1, e_phase(0), dir1, ed, oe1, e_oe[0]);
         end
      end
      checks++;
      if (n_oe !== 0) begin
         errors++;
         $display("FAIL abort_no_oe: %0d output_enable pulses, want 0", n_oe);
      end
   endtask

   task automatic test_reset_mid();
      int t0;
      descend = 1'b1; start = 1'b1;
      tick();
      start = 1'b0; t0 = cyc;
      while (cyc < t0 + 58) tick();
      checks++;
      if (ph1 !== 3'd7 || dir1 !== 8'hFF) begin
         errors++;
         $display("FAIL drain_state: ph %0d dir %h, want 7 FF", ph1, dir1);
      end
      #3;
      rst_n = 1'b0;
      #1;
      model_reset();
      checks++;
      if (ph1 !== 3'd0 || dir1 !== 8'h00 || rdy1 !== 1'b1 || bsy1 !== 1'b0 || tr1 !== 1'b0 || oe1 !== 1'b0) begin
         errors++;
         $display("FAIL async_reset: ph %0d dir %h rdy %b bsy %b tr %b oe %b, want 0 00 1 0 0 0", ph1, dir1, rdy1, bsy1, tr1, oe1);
      end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      start = 1'b1; abort = 1'b1;
      tick();
      start = 1'b0; abort = 1'b0;
      checks++;
      if (ph1 !== 3'd0 || rdy1 !== 1'b1 || bsy1 !== 1'b0 || tr1 !== 1'b0 || m_act[0] !== 1'b0) begin
         errors++;
         $display("FAIL start_abort: ph %0d rdy %b bsy %b tr %b, want 0 1 0 0", ph1, rdy1, bsy1, tr1);
      end
   endtask

   task automatic test_busy_start();
      int n_oe;
      logic [7:0] ed;
      descend = 1'b0; start = 1'b1;
      tick();
      n_oe = 0;
      for (int i = 1; i < 75; i++) begin
         start = (i > 3 && i < 58 && $urandom_range(0, 3) == 0) ? 1'b1 : 1'b0;
         tick();
         ed = e_dir(0);
         if (oe1) n_oe++;
         checks++;
         if (ph1 !== 3'(e_phase(0)) || dir1 !== ed || tr1 !== e_tr[0] || oe1 !== e_oe[0]) begin
            errors++;
            $display("FAIL busy_start cyc %0d: ph %0d/%0d dir %h/%h tr %b/%b oe %b/%b", cyc, ph1, e_phase(0), dir1, ed, tr1, e_tr[0], oe1, e_oe[0]);
         end
      end
      start = 1'b0;
      checks++;
      if (n_oe !== 1) begin
         errors++;
         $display("FAIL busy_start_oe: %0d output_enable pulses, want 1", n_oe);
      end
   endtask

   task automatic test_small();
      int t0, oe_at;
      logic [7:0] ed;
      logic [3:0] seen[$];
      logic [3:0] want[4];
      want = '{4'h0, 4'h5, 4'h0, 4'h0};
      descend2 = 1'b0; start2 = 1'b1;
      tick();
      start2 = 1'b0; t0 = cyc; oe_at = -1;
      for (int i = 0; i < 20; i++) begin
         if (i > 0) tick();
         ed = e_dir(1);
         checks++;
         if (ph2 !== 3'(e_phase(1)) || dir2 !== ed[3:0] || tr2 !== e_tr[1] || oe2 !== e_oe[1] || rdy2 !== !m_act[1]) begin
            errors++;
            $display("FAIL small cyc %0d: ph %0d/%0d dir %h/%h tr %b/%b oe %b/%b", cyc, ph2, e_phase(1), dir2, ed[3:0], tr2, e_tr[1], oe2, e_oe[1]);
         end
         if (tr2) seen.push_back(dir2);
         if (oe2) oe_at = cyc;
      end
      checks++;
      if (oe_at - t0 !== 12 || seen.size() !== 4) begin
         errors++;
         $display("FAIL small_timing: oe after %0d, trans %0d, want 12 and 4", oe_at - t0, seen.size());
      end else begin
         for (int k = 0; k < 4; k++) begin
            checks++;
            if (seen[k] !== want[k]) begin
               errors++;
               $display("FAIL small_dir phase %0d: %h, want %h", k + 1, seen[k], want[k]);
            end
         end
      end
   endtask

   task automatic test_random();
      logic [7:0] ed1, ed2;
      for (int i = 0; i < 3000; i++) begin
         en       = ($urandom_range(0, 7) != 0);
         start    = ($urandom_range(0, 3) == 0);
         abort    = ($urandom_range(0, 59) == 0);
         descend  = $urandom_range(0, 1) == 1;
         en2      = ($urandom_range(0, 5) != 0);
         start2   = ($urandom_range(0, 2) == 0);
         abort2   = ($urandom_range(0, 39) == 0);
         descend2 = $urandom_range(0, 1) == 1;
         tick();
         ed1 = e_dir(0);
         ed2 = e_dir(1);
         checks++;
         if (ph1 !== 3'(e_phase(0)) || dir1 !== ed1 || tr1 !== e_tr[0] || oe1 !== e_oe[0] || rdy1 !== !m_act[0] || bsy1 !== m_act[0]) begin
            errors++;
            $display("FAIL random dut cyc %0d: ph %0d/%0d dir %h/%h tr %b/%b oe %b/%b rdy %b", cyc, ph1, e_phase(0), dir1, ed1, tr1, e_tr[0], oe1, e_oe[0], rdy1);
         end
         checks++;
         if (ph2 !== 3'(e_phase(1)) || dir2 !== ed2[3:0] || tr2 !== e_tr[1] || oe2 !== e_oe[1] || rdy2 !== !m_act[1] || bsy2 !== m_act[1]) begin
            errors++;
            $display("FAIL random small cyc %0d: ph %0d/%0d dir %h/%h tr %b/%b oe %b/%b rdy %b", cyc, ph2, e_phase(1), dir2, ed2[3:0], tr2, e_tr[1], oe2, e_oe[1], rdy2);
         end
      end
      en = 1'b1; start = 1'b0; abort = 1'b0; en2 = 1'b1; start2 = 1'b0; abort2 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0;
      en = 1'b1; start = 1'b0; descend = 1'b0; abort = 1'b0;
      en2 = 1'b1; start2 = 1'b0; descend2 = 1'b0; abort2 = 1'b0;
      test_reset();
      test_sort(1'b0);
      test_sort(1'b1);
      test_en_freeze();
      test_abort();
      test_reset_mid();
      test_busy_start();
      test_small();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
